// File: rtl/pm_pkg.sv
// Shared sizing and shift-mode decode for the pixel-matrix column responder.
package pm_pkg;
  localparam int COLS   = 32;
  localparam int PIXELS = 8;
  localparam int CNT_W  = 8;
  localparam int CFG_W  = 4;

  typedef enum logic [1:0] {PM_IDLE, PM_RD, PM_CFG} pm_mode_t;

  // sh_a takes precedence, so {sh_b,sh_a}=11 also selects the readout chain
  function automatic pm_mode_t mode_decode(input logic sh_b, input logic sh_a);
    if (sh_a)      return PM_RD;
    else if (sh_b) return PM_CFG;
    else           return PM_IDLE;
  endfunction
endpackage

// File: rtl/pm_pixel.sv
// One matrix pixel: saturating hit counter, readout shadow and config shift stage
// (both serial, MSB out), plus the active config register.
module pm_pixel import pm_pkg::*; #(
  parameter int CNT_W = pm_pkg::CNT_W,
  parameter int CFG_W = pm_pkg::CFG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit,
  input  logic             gate,
  input  logic             strobe,
  input  logic             store,
  input  logic             rd_shift,
  input  logic             cfg_shift,
  input  logic             rd_si,
  input  logic             cfg_si,
  output logic             rd_so,
  output logic             cfg_so,
  output logic             rd_nxt,
  output logic             cfg_nxt,
  output logic [CFG_W-1:0] cfg_q
);
  logic [CNT_W-1:0] cnt, shadow;
  logic [CFG_W-1:0] cfg_sr;
  logic             qhit;

  assign qhit    = hit & gate & cfg_q[0];
  assign rd_so   = shadow[CNT_W-1];
  assign cfg_so  = cfg_sr[CFG_W-1];
  // bit that becomes the serial output once this pixel shifts
  assign rd_nxt  = shadow[CNT_W-2];
  assign cfg_nxt = cfg_sr[CFG_W-2];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      shadow <= '0;
      cfg_sr <= '0;
      cfg_q  <= '0;
    end else begin
      if (strobe) begin
        shadow <= cnt;
        cnt    <= qhit ? CNT_W'(1) : '0;
      end else begin
        if (rd_shift) shadow <= {shadow[CNT_W-2:0], rd_si};
        if (qhit && cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
      end
      if (store)     cfg_q  <= cfg_sr;
      if (cfg_shift) cfg_sr <= {cfg_sr[CFG_W-2:0], cfg_si};
    end
  end
endmodule

// File: rtl/pm_column_responder.sv
// Pixel-matrix responder: edge detection of PMC control lines, COLS x PIXELS pixel array,
// per-column registered serial output mux.
module pm_column_responder import pm_pkg::*; #(
  parameter int COLS   = pm_pkg::COLS,
  parameter int PIXELS = pm_pkg::PIXELS,
  parameter int CNT_W  = pm_pkg::CNT_W,
  parameter int CFG_W  = pm_pkg::CFG_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [COLS-1:0]               pm_store,
  input  logic [COLS-1:0]               pm_strobe,
  input  logic [COLS-1:0]               pm_gate,
  input  logic [COLS-1:0]               pm_sh_a,
  input  logic [COLS-1:0]               pm_sh_b,
  input  logic [COLS-1:0]               pm_clk_sh,
  input  logic [COLS-1:0]               pm_din,
  output logic [COLS-1:0]               pm_dout,
  input  logic [COLS*PIXELS-1:0]        hit,
  output logic [COLS*PIXELS*CFG_W-1:0]  cfg_q
);
  logic [COLS-1:0] store_q, strobe_q, clk_sh_q;
  logic [COLS-1:0] store_re, strobe_re, clk_sh_re;

  // cleared in reset, so a line already high at release counts as a rising edge
  always_ff @(posedge clk) begin
    if (rst) begin
      store_q  <= '0;
      strobe_q <= '0;
      clk_sh_q <= '0;
    end else begin
      store_q  <= pm_store;
      strobe_q <= pm_strobe;
      clk_sh_q <= pm_clk_sh;
    end
  end

  assign store_re  = pm_store  & ~store_q;
  assign strobe_re = pm_strobe & ~strobe_q;
  assign clk_sh_re = pm_clk_sh & ~clk_sh_q;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    pm_mode_t          mode;
    logic              rd_sh, cfg_sh, dout_r;
    logic [PIXELS:0]   rd_link, cfg_link;
    logic [PIXELS-1:0] rd_nxt, cfg_nxt;
    logic              unused_tap;

    assign mode        = mode_decode(pm_sh_b[c], pm_sh_a[c]);
    assign rd_sh       = clk_sh_re[c] && (mode == PM_RD);
    assign cfg_sh      = clk_sh_re[c] && (mode == PM_CFG);
    assign rd_link[0]  = pm_din[c];
    assign cfg_link[0] = pm_din[c];
    // only the last pixel's look-ahead bit feeds the output register
    assign unused_tap  = ^{rd_nxt, cfg_nxt};

    for (genvar p = 0; p < PIXELS; p++) begin : g_pix
      pm_pixel #(.CNT_W(CNT_W), .CFG_W(CFG_W)) u_pix (
        .clk       (clk),
        .rst       (rst),
        .hit       (hit[c*PIXELS+p]),
        .gate      (pm_gate[c]),
        .strobe    (strobe_re[c]),
        .store     (store_re[c]),
        .rd_shift  (rd_sh),
        .cfg_shift (cfg_sh),
        .rd_si     (rd_link[p]),
        .cfg_si    (cfg_link[p]),
        .rd_so     (rd_link[p+1]),
        .cfg_so    (cfg_link[p+1]),
        .rd_nxt    (rd_nxt[p]),
        .cfg_nxt   (cfg_nxt[p]),
        .cfg_q     (cfg_q[(c*PIXELS+p)*CFG_W +: CFG_W])
      );
    end

    // on a shift show the post-shift last bit; otherwise re-select the current one
    always_ff @(posedge clk) begin
      if (rst) begin
        dout_r <= 1'b0;
      end else begin
        case (mode)
          PM_RD:   dout_r <= rd_sh  ? rd_nxt[PIXELS-1]  : rd_link[PIXELS];
          PM_CFG:  dout_r <= cfg_sh ? cfg_nxt[PIXELS-1] : cfg_link[PIXELS];
          default: dout_r <= dout_r;
        endcase
      end
    end

    assign pm_dout[c] = dout_r;
  end
endmodule

// File: tb/tb_pm_column_responder.sv
// Randomized + directed bench for pm_column_responder against a flat-vector behavioural model.
module tb_pm_column_responder;
  localparam int COLS = 32, PIXELS = 8, CNT_W = 8, CFG_W = 4;
  localparam int RDW = PIXELS*CNT_W, CFW = PIXELS*CFG_W, CQW = COLS*PIXELS*CFG_W;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [COLS-1:0]      pm_store, pm_strobe, pm_gate, pm_sh_a, pm_sh_b, pm_clk_sh, pm_din, pm_dout;
  logic [COLS*PIXELS-1:0] hit;
  logic [CQW-1:0]       cfg_q;

  always #5 clk = ~clk;

  pm_column_responder dut (
    .clk(clk), .rst(rst), .pm_store(pm_store), .pm_strobe(pm_strobe), .pm_gate(pm_gate),
    .pm_sh_a(pm_sh_a), .pm_sh_b(pm_sh_b), .pm_clk_sh(pm_clk_sh), .pm_din(pm_din),
    .pm_dout(pm_dout), .hit(hit), .cfg_q(cfg_q)
  );

  int total = 0, bad = 0;

  // model: each column's chains as flat vectors, bit 0 = pixel 0 LSB, top bit = serial out
  int               m_cnt [COLS][PIXELS];
  logic [RDW-1:0]   m_rd  [COLS];
  logic [CFW-1:0]   m_cf  [COLS];
  logic [CFG_W-1:0] m_act [COLS][PIXELS];
  logic [COLS-1:0]  m_dout, p_store, p_strobe, p_sh;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CFW-1:0] act_flat(input int c);
    logic [CFW-1:0] v;
    for (int p = 0; p < PIXELS; p++) v[p*CFG_W +: CFG_W] = m_act[c][p];
    return v;
  endfunction

  task automatic step();
    logic [COLS-1:0] st_r, sb_r, sh_r;
    st_r = pm_store & ~p_store;
    sb_r = pm_strobe & ~p_strobe;
    sh_r = pm_clk_sh & ~p_sh;
    if (rst) begin
      for (int c = 0; c < COLS; c++) begin
        m_rd[c] = '0; m_cf[c] = '0;
        for (int p = 0; p < PIXELS; p++) begin m_cnt[c][p] = 0; m_act[c][p] = '0; end
      end
      m_dout = '0; p_store = '0; p_strobe = '0; p_sh = '0;
    end else begin
      for (int c = 0; c < COLS; c++) begin
        logic [RDW-1:0] rd_n;
        logic [CFW-1:0] cf_n;
        bit rd_m, cf_m, q;
        rd_m = pm_sh_a[c];
        cf_m = !pm_sh_a[c] && pm_sh_b[c];
        rd_n = m_rd[c];
        cf_n = m_cf[c];
        if (sh_r[c] && rd_m) rd_n = {m_rd[c][RDW-2:0], pm_din[c]};
        if (sh_r[c] && cf_m) cf_n = {m_cf[c][CFW-2:0], pm_din[c]};
        if (rd_m)      m_dout[c] = rd_n[RDW-1];
        else if (cf_m) m_dout[c] = cf_n[CFW-1];
        for (int p = 0; p < PIXELS; p++) begin
          q = hit[c*PIXELS+p] && pm_gate[c] && m_act[c][p][0];
          if (sb_r[c]) begin
            rd_n[p*CNT_W +: CNT_W] = CNT_W'(m_cnt[c][p]);
            m_cnt[c][p] = q ? 1 : 0;
          end else if (q) begin
            m_cnt[c][p] = (m_cnt[c][p] + 1 > 255) ? 255 : m_cnt[c][p] + 1;
          end
          if (st_r[c]) m_act[c][p] = m_cf[c][p*CFG_W +: CFG_W];
        end
        m_rd[c] = rd_n;
        m_cf[c] = cf_n;
      end
      p_store = pm_store; p_strobe = pm_strobe; p_sh = pm_clk_sh;
    end
    @(posedge clk);
    #1;
    chk("dout", {32'b0, pm_dout}, {32'b0, m_dout});
    for (int c = 0; c < COLS; c++)
      chk($sformatf("cfg_col%0d", c), {32'b0, cfg_q[c*CFW +: CFW]}, {32'b0, act_flat(c)});
  endtask

  task automatic idle_inputs();
    pm_store = '0; pm_strobe = '0; pm_gate = '0; pm_sh_a = '0; pm_sh_b = '0;
    pm_clk_sh = '0; pm_din = '0; hit = '0;
  endtask

  task automatic rand_inputs();
    pm_store = $urandom; pm_strobe = $urandom; pm_gate = $urandom; pm_sh_a = $urandom;
    pm_sh_b = $urandom; pm_clk_sh = $urandom; pm_din = $urandom;
    for (int i = 0; i < COLS*PIXELS; i++) hit[i] = ($urandom_range(0, 3) == 0);
  endtask

  task automatic pulse_strobe(input int c);
    pm_strobe[c] = 1'b1; step();
    pm_strobe[c] = 1'b0; step();
  endtask

  task automatic hits(input int c, input int p, input int n);
    for (int i = 0; i < n; i++) begin
      hit[c*PIXELS+p] = 1'b1; step();
      hit[c*PIXELS+p] = 1'b0; step();
    end
  endtask

  task automatic read_col(input int c, output logic [RDW-1:0] w);
    pm_sh_a[c] = 1'b1; pm_din[c] = 1'b0; step();
    for (int i = RDW-1; i >= 0; i--) begin
      w[i] = pm_dout[c];
      if (i > 0) begin
        pm_clk_sh[c] = 1'b1; step();
        pm_clk_sh[c] = 1'b0; step();
      end
    end
    pm_sh_a[c] = 1'b0; step();
  endtask

  initial begin
    logic [RDW-1:0] w;
    logic [31:0]    pat, en;
    pat = 32'h5A3C_F00F;
    en  = 32'h1111_1111;
    idle_inputs();
    p_store = '0; p_strobe = '0; p_sh = '0;

    // reset with random activity on every line
    rst = 1'b1;
    rand_inputs(); step();
    rand_inputs(); step();
    chk("rst_dout", {32'b0, pm_dout}, 64'd0);
    chk("rst_cfg_lo", cfg_q[63:0], 64'd0);

    // random phase against the model
    rst = 1'b0;
    for (int i = 0; i < 120; i++) begin rand_inputs(); step(); end

    // reset from random state
    rst = 1'b1;
    rand_inputs(); step();
    rand_inputs(); step();
    chk("rst2_dout", {32'b0, pm_dout}, 64'd0);
    chk("rst2_cfg_hi", cfg_q[CQW-1 -: 64], 64'd0);
    idle_inputs(); rst = 1'b0; step();
    read_col(7, w);
    chk("rst2_counters", w, 64'd0);

    // config load of column 3
    pm_sh_b[3] = 1'b1; step();
    for (int i = 31; i >= 0; i--) begin
      pm_din[3] = pat[i]; pm_clk_sh[3] = 1'b1; step();
      pm_clk_sh[3] = 1'b0; step();
    end
    pm_store[3] = 1'b1; step();
    chk("cfg_col3", {32'b0, cfg_q[3*CFW +: CFW]}, {32'b0, pat});
    chk("cfg_col2_zero", {32'b0, cfg_q[2*CFW +: CFW]}, 64'd0);
    chk("cfg_col4_zero", {32'b0, cfg_q[4*CFW +: CFW]}, 64'd0);
    pm_store[3] = 1'b0; pm_sh_b[3] = 1'b0; pm_din[3] = 1'b0; step();

    // masking: pixel 1 of col 3 disabled by cfg, pixel 0 enabled but gate low
    pm_gate[3] = 1'b1; hits(3, 1, 3);
    pm_gate[3] = 1'b0; hits(3, 0, 3);
    pulse_strobe(3);
    read_col(3, w);
    chk("mask_gate", w, 64'd0);

    // enable every pixel of every column
    pm_sh_b = '1; step();
    for (int i = 31; i >= 0; i--) begin
      pm_din = {COLS{en[i]}}; pm_clk_sh = '1; step();
      pm_clk_sh = '0; step();
    end
    pm_store = '1; step();
    chk("cfg_all_col0", {32'b0, cfg_q[0 +: CFW]}, {32'b0, en});
    chk("cfg_all_col31", {32'b0, cfg_q[31*CFW +: CFW]}, {32'b0, en});
    pm_store = '0; pm_sh_b = '0; pm_din = '0; step();

    // five hits on pixel 2 of column 0
    pm_gate[0] = 1'b1;
    hits(0, 2, 5);
    pulse_strobe(0);
    read_col(0, w);
    chk("count5", w, 64'h0000_0000_0005_0000);
    pulse_strobe(0);
    read_col(0, w);
    chk("count_cleared", w, 64'd0);

    // saturation
    hit[5] = 1'b1;
    for (int i = 0; i < 300; i++) step();
    hit[5] = 1'b0; step();
    pulse_strobe(0);
    read_col(0, w);
    chk("saturate", w, 64'h0000_FF00_0000_0000);

    // strobe edge coinciding with a qualified hit
    hits(0, 4, 3);
    hit[4] = 1'b1; pm_strobe[0] = 1'b1; step();
    hit[4] = 1'b0; pm_strobe[0] = 1'b0; step();
    read_col(0, w);
    chk("simul_shadow", w, 64'h0000_0003_0000_0000);
    pulse_strobe(0);
    read_col(0, w);
    chk("simul_counter", w, 64'h0000_0001_0000_0000);

    // reset in the middle of a readout shift
    hits(0, 7, 9);
    pulse_strobe(0);
    pm_sh_a[0] = 1'b1; pm_din[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pm_clk_sh[0] = 1'b1; step();
      pm_clk_sh[0] = 1'b0; step();
    end
    rst = 1'b1;
    pm_clk_sh[0] = 1'b1; step();
    pm_clk_sh[0] = 1'b0; step();
    chk("rst_mid_dout", {63'b0, pm_dout[0]}, 64'd0);
    rst = 1'b0; idle_inputs(); step();
    pm_sh_a[0] = 1'b1; step();
    pm_clk_sh[0] = 1'b1; step();
    chk("rst_mid_first_shift", {63'b0, pm_dout[0]}, 64'd0);
    pm_clk_sh[0] = 1'b0; pm_sh_a[0] = 1'b0; step();
    read_col(0, w);
    chk("rst_mid_chain", w, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
